// File: rtl/coin_pkg.sv
// Shared types and constants for the coin acceptor: FSM states, sorter codes,
// denomination values, default parameters and the code-to-value decoder.
package coin_pkg;

    localparam int unsigned CREDIT_W = 4;
    localparam int unsigned SUM_W    = CREDIT_W + 1;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned CODE_W   = 2;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEFAULT_MAX_CREDIT      = 15;

    typedef enum logic [2:0] {
        IDLE,
        QUALIFY,
        COMMIT,
        SETTLE,
        STROBE,
        REJECT,
        RELEASE
    } state_t;

    localparam logic [CODE_W-1:0] COIN_1   = 2'b00;
    localparam logic [CODE_W-1:0] COIN_2   = 2'b01;
    localparam logic [CODE_W-1:0] COIN_5   = 2'b10;
    localparam logic [CODE_W-1:0] COIN_BAD = 2'b11;

    localparam logic [CREDIT_W-1:0] VALUE_1 = 4'd1;
    localparam logic [CREDIT_W-1:0] VALUE_2 = 4'd2;
    localparam logic [CREDIT_W-1:0] VALUE_5 = 4'd5;

    // Sorter code to credit value; the invalid code maps to zero and is
    // rejected separately by the FSM.
    function automatic logic [CREDIT_W-1:0] coin_value_of(input logic [CODE_W-1:0] code);
        logic [CREDIT_W-1:0] val;
        case (code)
            COIN_1:  val = VALUE_1;
            COIN_2:  val = VALUE_2;
            COIN_5:  val = VALUE_5;
            default: val = '0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Coin acceptor bus: raw sensor/sorter inputs and clear request in,
// credit, strobe, reject and busy out.
//   master: vending side / sensor model (drives coin_sense, coin_type, clear)
//   slave:  coin_acceptor
interface coin_acceptor_if;
    import coin_pkg::*;

    logic                coin_sense;
    logic [CODE_W-1:0]   coin_type;
    logic                clear;
    logic                coin_in;
    logic [CREDIT_W-1:0] coin_value;
    logic                reject;
    logic                busy;

    modport master (
        output coin_sense, coin_type, clear,
        input  coin_in, coin_value, reject, busy
    );

    modport slave (
        input  coin_sense, coin_type, clear,
        output coin_in, coin_value, reject, busy
    );
endinterface

// File: rtl/coin_sync.sv
// Two-flop synchroniser for asynchronous level inputs.
//   clk, rst : clock and synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronised output, RST_VAL while in reset
module coin_sync #(
    parameter int unsigned           WIDTH   = 1,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/coin_acceptor.sv
// Coin slot front end: synchronises and debounces the sensor, decodes the
// sorter code and keeps a saturating credit total with a one-cycle accept
// strobe issued a cycle after the credit has settled.
//   clk, rst : clock and synchronous active-high reset
//   bus      : coin_acceptor_if.slave (coin_sense, coin_type, clear in;
//              coin_in, coin_value, reject, busy out, all registered)
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned MAX_CREDIT      = DEFAULT_MAX_CREDIT
) (
    input  logic           clk,
    input  logic           rst,
    coin_acceptor_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'(MAX_CREDIT);

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic [CODE_W-1:0]   code_q;
    logic [CREDIT_W-1:0] credit;
    logic                coin_in_q;
    logic                reject_q;
    logic                busy_q;

    logic                sense_s;
    logic [CODE_W-1:0]   type_s;

    logic [CREDIT_W-1:0] base;
    logic [SUM_W-1:0]    sum;
    logic                refuse;

    // Sensor syncs reset high so a coin present during reset looks like one
    // still in the slot and must be released before anything is credited.
    coin_sync #(.WIDTH(1), .RST_VAL(1'b1)) u_sense_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.coin_sense),
        .q   (sense_s)
    );

    coin_sync #(.WIDTH(CODE_W), .RST_VAL('0)) u_type_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.coin_type),
        .q   (type_s)
    );

    // Coin evaluation: a coincident clear zeroes the credit before the add.
    always_comb begin
        base   = bus.clear ? '0 : credit;
        sum    = SUM_W'(base) + SUM_W'(coin_value_of(code_q));
        refuse = (code_q == COIN_BAD) || (sum > CREDIT_MAX);
    end

    // FSM, debounce counter and credit accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RELEASE;
            count     <= '0;
            code_q    <= COIN_1;
            credit    <= '0;
            coin_in_q <= 1'b0;
            reject_q  <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            coin_in_q <= 1'b0;
            reject_q  <= 1'b0;
            if (bus.clear) begin
                credit <= '0;
            end

            case (state)
                IDLE: begin
                    if (sense_s) begin
                        state  <= QUALIFY;
                        count  <= CNT_W'(1);
                        busy_q <= 1'b1;
                    end
                end
                QUALIFY: begin
                    if (!sense_s) begin
                        state  <= IDLE;
                        count  <= '0;
                        busy_q <= 1'b0;
                    end else if (count == CNT_LAST) begin
                        state  <= COMMIT;
                        code_q <= type_s;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                COMMIT: begin
                    if (refuse) begin
                        state    <= REJECT;
                        reject_q <= 1'b1;
                    end else begin
                        state  <= SETTLE;
                        credit <= sum[CREDIT_W-1:0];
                    end
                end
                SETTLE: begin
                    state     <= STROBE;
                    coin_in_q <= 1'b1;
                end
                STROBE, REJECT: begin
                    state <= RELEASE;
                    count <= '0;
                end
                RELEASE: begin
                    // Any sensor high restarts the quiet-time count.
                    if (sense_s) begin
                        count <= '0;
                    end else if (count == CNT_LAST) begin
                        state  <= IDLE;
                        count  <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= RELEASE;
                    count  <= '0;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.coin_in    = coin_in_q;
    assign bus.coin_value = credit;
    assign bus.reject     = reject_q;
    assign bus.busy       = busy_q;
endmodule
